// File: rtl/scan_sequencer_pkg.sv
// Shared types and defaults for the decoder scan sequencer.
package scan_sequencer_pkg;

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b01;

    localparam int unsigned DIV_MAX_DEF = 100000;
    localparam int unsigned DIV_W_DEF   = 17;
    localparam int unsigned GAP_CYC_DEF = 4;
    localparam int unsigned GAP_W_DEF   = 3;

    // Modulo-8 channel step in the requested direction.
    function automatic logic [2:0] step_idx(input logic [2:0] idx, input logic dir);
        return dir ? idx - 3'd1 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/scan_sequencer_rise_edge_det.sv
// Rising-edge detector: pulses while the input is high and was low last cycle.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic iSig,
    output logic oPulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= iSig;
        end
    end

    assign oPulse = iSig & ~prev;

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexing channel sequencer feeding a 3-to-8 decoder, with
// blanking gaps between channels and stop/single-step/direction control.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int unsigned DIV_MAX = DIV_MAX_DEF,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned GAP_CYC = GAP_CYC_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iRun,
    input  logic       iStep,
    input  logic       iDir,
    input  logic       iBlank,
    output logic [2:0] oData,
    output logic [1:0] oEna,
    output logic       oTick,
    output logic       oWrap
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       ena_q, ena_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             advance;
    logic             step_pulse;

    rise_edge_det u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .iSig   (iStep),
        .oPulse (step_pulse)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_STOP;
            idx_q   <= 3'd0;
            div_q   <= '0;
            gap_q   <= '0;
            ena_q   <= ENA_OFF;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            ena_q   <= ena_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state, counters and advance decision.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        advance = 1'b0;

        case (state_q)
            S_STOP: begin
                if (iRun) begin
                    state_d = S_SHOW;
                    div_d   = '0;
                end else if (step_pulse) begin
                    advance = 1'b1;
                end
            end
            S_SHOW: begin
                if (!iRun) begin
                    state_d = S_STOP;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                // The gap always runs to completion; iRun only picks the exit.
                if (gap_q == GAP_LAST) begin
                    advance = 1'b1;
                    gap_d   = '0;
                    div_d   = '0;
                    state_d = iRun ? S_SHOW : S_STOP;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_STOP;
                div_d   = '0;
                gap_d   = '0;
            end
        endcase

        idx_d  = advance ? step_idx(idx_q, iDir) : idx_q;
        tick_d = advance;
        wrap_d = advance && (iDir ? (idx_q == 3'd0) : (idx_q == 3'd7));
        ena_d  = ((state_d != S_GAP) && !iBlank) ? ENA_ON : ENA_OFF;
    end

    assign oData = idx_q;
    assign oEna  = ena_q;
    assign oTick = tick_q;
    assign oWrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer against a period-counter reference model.
module tb_scan_sequencer;

    localparam int D = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iRun = 1'b0, iStep = 1'b0, iDir = 1'b0, iBlank = 1'b0;
    logic [2:0] oData;
    logic [1:0] oEna;
    logic       oTick, oWrap;

    int n_cmp = 0;
    int n_bad = 0;

    scan_sequencer #(.DIV_MAX(D), .DIV_W(3), .GAP_CYC(G), .GAP_W(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .iRun   (iRun),
        .iStep  (iStep),
        .iDir   (iDir),
        .iBlank (iBlank),
        .oData  (oData),
        .oEna   (oEna),
        .oTick  (oTick),
        .oWrap  (oWrap)
    );

    always #5 clk = ~clk;

    // Reference: one counter t walks the whole D+G period; t >= D is the gap.
    bit         m_run  = 1'b0;
    int         m_t    = 0;
    int         m_idx  = 0;
    bit         m_prev = 1'b0;
    logic [1:0] m_ena  = 2'b01;
    bit         m_tick = 1'b0;
    bit         m_wrap = 1'b0;

    always @(posedge clk) begin : model
        bit stp;
        bit adv;
        if (rst) begin
            m_run = 0; m_t = 0; m_idx = 0; m_prev = 0;
            m_ena = 2'b01; m_tick = 0; m_wrap = 0;
        end else begin
            stp    = iStep && !m_prev;
            m_prev = iStep;
            adv    = 0;
            if (!m_run) begin
                if (iRun) begin
                    m_run = 1; m_t = 0;
                end else if (stp) begin
                    adv = 1;
                end
            end else if (m_t < D && !iRun) begin
                m_run = 0; m_t = 0;
            end else if (m_t == D + G - 1) begin
                adv = 1; m_t = 0; m_run = iRun;
            end else begin
                m_t = m_t + 1;
            end
            m_ena  = (!(m_run && m_t >= D) && !iBlank) ? 2'b10 : 2'b01;
            m_tick = adv;
            m_wrap = adv && (iDir ? (m_idx == 0) : (m_idx == 7));
            if (adv) m_idx = (m_idx + (iDir ? 7 : 1)) % 8;
        end
    end

    function automatic logic [6:0] exp_vec();
        return {3'(m_idx), m_ena, m_tick, m_wrap};
    endfunction

    task automatic test_reset();
        rst = 1; iRun = 1; iDir = 0; iBlank = 0; iStep = 0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== 7'b000_01_0_0) begin
                n_bad++;
                $display("FAIL reset_state: got %b required 0000100", {oData, oEna, oTick, oWrap});
            end
        end
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if (oEna !== 2'b10 || oData !== 3'd0 || oTick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: data %0d ena %b tick %b, required 0 10 0", oData, oEna, oTick);
        end
    endtask

    task automatic test_scan_up();
        int last = -1;
        int wraps = 0;
        iRun = 1; iDir = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan_up cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
            if (oTick) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != D + G) begin
                        n_bad++;
                        $display("FAIL scan_up_period: got %0d required %0d", i - last, D + G);
                    end
                end
                last = i;
            end
            if (oWrap) begin
                wraps++;
                n_cmp++;
                if (oData !== 3'd0 || oTick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL scan_up_wrap: data %0d tick %b, required 0 1", oData, oTick);
                end
            end
        end
        n_cmp++;
        if (wraps != 1) begin
            n_bad++;
            $display("FAIL scan_up_wrap_count: got %0d required 1", wraps);
        end
    endtask

    task automatic test_scan_down();
        rst = 1; iRun = 1; iDir = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan_down cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
            if (i == 7) begin
                n_cmp++;
                if (oData !== 3'd7 || oTick !== 1'b1 || oWrap !== 1'b1) begin
                    n_bad++;
                    $display("FAIL scan_down_wrap: data %0d tick %b wrap %b, required 7 1 1", oData, oTick, oWrap);
                end
            end
        end
        iDir = 0;
    endtask

    task automatic test_stop_step();
        int  ticks = 0;
        bit  found = 0;
        rst = 1; iRun = 1; iDir = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = oTick && (oData == 3'd3);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL stop_wait_idx3: index 3 not reached, data %0d required 3", oData);
        end
        repeat (2) @(negedge clk);
        iRun = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (oData !== 3'd3 || oEna !== 2'b10 || oTick !== 1'b0 || {oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_hold cyc %0d: data %0d ena %b tick %b, required 3 10 0", i, oData, oEna, oTick);
            end
        end
        iStep = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (oTick) ticks++;
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL step_held cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
        end
        n_cmp++;
        if (ticks != 1 || oData !== 3'd4) begin
            n_bad++;
            $display("FAIL step_once: ticks %0d data %0d, required 1 4", ticks, oData);
        end
        iStep = 0;
        @(negedge clk);
        iRun = 1; iStep = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (oData !== 3'd4 || oTick !== 1'b0) begin
                n_bad++;
                $display("FAIL run_beats_step cyc %0d: data %0d tick %b, required 4 0", i, oData, oTick);
            end
        end
        iStep = 0;
    endtask

    task automatic test_blank();
        int ticks = 0;
        rst = 1; iRun = 1; iBlank = 0;
        @(negedge clk);
        rst = 0; iBlank = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oTick) ticks++;
            n_cmp++;
            if (oEna !== 2'b01 || {oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL blank cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
        end
        n_cmp++;
        if (ticks != 3) begin
            n_bad++;
            $display("FAIL blank_ticks: got %0d required 3", ticks);
        end
        iBlank = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL unblank cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
        end
    endtask

    task automatic test_gap_reset();
        bit found = 0;
        rst = 1; iRun = 1; iBlank = 0; iDir = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = (oData == 3'd5) && (oEna == 2'b01);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL gap_wait_idx5: gap at index 5 not reached, data %0d ena %b", oData, oEna);
        end
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if (oData !== 3'd0 || oEna !== 2'b01 || oTick !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_reset: data %0d ena %b tick %b, required 0 01 0", oData, oEna, oTick);
        end
        rst = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== exp_vec() || (oTick === 1'b1) != (i == 7)) begin
                n_bad++;
                $display("FAIL gap_restart cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(19) == 0) iRun = ~iRun;
            if ($urandom_range(2) == 0)  iStep = ~iStep;
            if ($urandom_range(9) == 0)  iDir = ~iDir;
            if ($urandom_range(19) == 0) iBlank = ~iBlank;
            @(negedge clk);
            n_cmp++;
            if ({oData, oEna, oTick, oWrap} !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %b required %b", i, {oData, oEna, oTick, oWrap}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_up();
        test_scan_down();
        test_stop_step();
        test_blank();
        test_gap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Time-multiplexing sequencer that sits directly upstream of the 3-to-8 decoder and drives its iData/iEna inputs. It steps a 3-bit channel index through 0..7 at a prescaled rate. Between channels it inserts a blanking gap with the decoder disabled, which stops ghosting on multiplexed LED/7-segment digit selects. It also supports stop, single-step, direction and blanking control.

Parameters:
DIV_MAX, 100000, clock cycles each channel is shown (≥1); 1 kHz channel rate at 100 MHz
DIV_W, 17, prescaler counter width (≥ clog2(DIV_MAX))
GAP_CYC, 4, blanking cycles between channels (0 = no gap)
GAP_W, 3, gap counter width (≥ clog2(GAP_CYC+1))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
iRun  input  1  level; 1 = auto-scan, 0 = stop
iStep  input  1  single-step request; acts on rising edge, only when stopped
iDir  input  1  0 = index increments, 1 = index decrements
iBlank  input  1  level; 1 forces decoder disabled, index keeps running
oData  output  3  channel index, connects to decoder iData
oEna  output  2  decoder enable, connects to iEna; 2'b10 = enabled, 2'b01 = disabled
oTick  output  1  one-cycle pulse in the cycle a new index first appears on oData
oWrap  output  1  one-cycle pulse with oTick when index goes 7->0 (up) or 0->7 (down)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset (rst=1 at a clock edge): state=S_STOP, idx=0, div=0, gap=0, step edge register=0, oData=0, oEna=2'b01, oTick=0, oWrap=0. Reset overrides every other input.
- FSM states: S_STOP, S_SHOW, S_GAP.
- S_STOP -> S_SHOW when iRun=1; div cleared. idx is held.
- S_SHOW: div counts 0..DIV_MAX-1.
  - At div=DIV_MAX-1 with GAP_CYC>0: go to S_GAP, gap cleared.
  - At div=DIV_MAX-1 with GAP_CYC=0: advance idx, div returns to 0, stay in S_SHOW.
  - iRun=0 in S_SHOW: go to S_STOP at the next edge; div cleared, no advance.
- S_GAP: counts GAP_CYC cycles.
  - On the last gap cycle: advance idx, then go to S_SHOW if iRun=1, else S_STOP.
  - The gap always completes once entered, even if iRun drops.
- Advance: idx <= iDir ? idx-1 : idx+1, modulo 8. iDir is sampled in the advance cycle only.
  - oTick=1 for exactly the one cycle in which the new idx first appears on oData.
  - oWrap=1 in that same cycle if the advance was 7->0 (up) or 0->7 (down).
- oEna register loads 2'b10 when (next state != S_GAP and iBlank=0); otherwise it loads 2'b01.
  - Consequence: the decoder is enabled in S_STOP and S_SHOW, disabled during the gap, and blanked by iBlank one cycle later.
- Latency: with GAP_CYC=G and DIV_MAX=D, a new index appears every D+G cycles. oData updates on the edge after the last gap cycle, and oEna returns to 2'b10 on that same edge.
- iStep:
  - Rising edge is detected against the value registered on the previous cycle.
  - In S_STOP with iRun=0, an edge advances idx immediately (no gap) and pulses oTick/oWrap as above.
  - iStep held high gives exactly one step.
  - Edges in S_SHOW or S_GAP are ignored. Iterating steps do not wait for DIV_MAX.
- Simultaneous iRun=1 and iStep edge in S_STOP: the run wins and the step is discarded.
- iBlank never affects idx, div, oTick or oWrap.

Decomposition:
- Shared package:
  - state encoding: S_STOP=2'd0, S_SHOW=2'd1, S_GAP=2'd2
  - ENA_ON=2'b10, ENA_OFF=2'b01
  - default DIV_MAX and GAP_CYC
- Sub-module: rise_edge_det (clk, rst, iSig -> oPulse), used for iStep. It can be reused for button inputs elsewhere.

Test Plan:
1. rst=1 for 2 cycles with iRun=1 -> oData=0, oEna=2'b01, oTick=0, oWrap=0. First edge after release enters S_SHOW and oEna=2'b10.
2. DIV_MAX=4, GAP_CYC=2, iRun=1, iDir=0:
   - oData=0 with oEna=10 for 4 cycles, then oEna=01 for 2 cycles.
   - oData=1 with oEna=10 and oTick pulse; period is 6 cycles.
   - Advance 7->0 pulses oWrap together with oTick.
3. Same params, iDir=1 from idx=0 -> after 6 cycles oData=7, with oTick and oWrap both high for one cycle.
4. At idx=3 drop iRun mid-S_SHOW -> oData stays 3, oEna=10, no oTick for 20 cycles. Then hold iStep high 5 cycles -> oData=4 once, single oTick. iStep edge while iRun=1 -> no extra advance.
5. iBlank=1 during run -> oEna=01 continuously, oData keeps stepping 0,1,2 with oTick each 6 cycles. iBlank=0 restores oEna=10 next cycle, except during a gap.
6. rst=1 during S_GAP at idx=5 -> next cycle oData=0, oEna=01, no oTick. With iRun=1 after release, the scan restarts from 0 with full DIV_MAX dwell.
